// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a word over valid/ready and shifts it out
// one bit per accepted beat, MSB- or LSB-first, streaming back-to-back frames gap-free.
module piso_tx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  msb_first,
    output logic                  serial_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(DATA_WIDTH);

    generate
        if (DATA_WIDTH < 2) begin : g_bad_width
            $error("piso_tx: DATA_WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  dir_q;
    logic [CW-1:0]         cnt;
    logic                  frame_done_q;

    logic last_bit;
    logic xfer;
    logic accept;

    assign last_bit   = (cnt == CW'(DATA_WIDTH - 1));
    assign out_valid  = (state == SHIFT);
    assign busy       = out_valid;
    assign xfer       = out_valid && out_ready;
    // Ready during the last-bit beat so the next word loads on the same edge: no idle gap.
    assign in_ready   = (state == IDLE) || (xfer && last_bit);
    assign accept     = in_valid && in_ready;
    assign serial_out = out_valid && (dir_q ? sreg[DATA_WIDTH-1] : sreg[0]);
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            sreg         <= '0;
            dir_q        <= 1'b0;
            cnt          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= xfer && last_bit;
            if (accept) begin
                sreg  <= parallel_in;
                dir_q <= msb_first;
                cnt   <= '0;
                state <= SHIFT;
            end else if (xfer) begin
                sreg <= dir_q ? (sreg << 1) : (sreg >> 1);
                if (last_bit) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
